// File: rtl/obs_sprite_rom.sv
// Obstacle sprite ROM: one registered pixel per request, with a bird wing-flap frame counter.
// Optional build macro OBS_ROM_HFLIP_EN adds the i_hflip port for horizontal mirroring.
module obs_sprite_rom #(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int ANIM_DIV = 8,
  localparam int XW      = $clog2(SPR_W),
  localparam int YW      = $clog2(SPR_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req_valid,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [2:0]    i_obs_type,
  input  logic          i_frame_tick,
  input  logic          i_anim_run,
`ifdef OBS_ROM_HFLIP_EN
  input  logic          i_hflip,
`endif
  output logic          o_pix_valid,
  output logic          o_sprite_color,
  output logic          o_oob,
  output logic          o_anim_frame
);

  localparam int NPIX = SPR_W * SPR_H;
  localparam int IW   = $clog2(NPIX);
  localparam int CW   = $clog2(ANIM_DIV) + 1;

  typedef enum logic [2:0] {
    T_EMPTY, T_CAC_3, T_CAC_2, T_CAC_THICK_1,
    T_CAC_THICK_2, T_CAC_THIN, T_BIRD_LOW, T_BIRD_HIGH
  } obs_type_e;

  typedef enum int {SH_CAC3, SH_CAC2, SH_THICK, SH_THIN, SH_BIRD_A, SH_BIRD_B} shape_e;

  // Shapes are drawn from proportions of the sprite box so every SPR_W x SPR_H gets a sensible bitmap.
  function automatic logic [NPIX-1:0] draw(input shape_e s);
    logic [NPIX-1:0] bm;
    logic            on;
    bm = '0;
    for (int y = 0; y < SPR_H; y++) begin
      for (int x = 0; x < SPR_W; x++) begin
        case (s)
          SH_CAC3:   on = (x % 5 == 1) && (y >= SPR_H / 4);
          SH_CAC2:   on = (x % 6 == 2) || (y == SPR_H - 1);
          SH_THICK:  on = (x >= SPR_W / 4 && x < (3 * SPR_W) / 4) ||
                          (y == SPR_H / 3 && x >= (3 * SPR_W) / 4);
          SH_THIN:   on = (x == SPR_W / 2) || (y == SPR_H / 2 && x < SPR_W / 2);
          SH_BIRD_A: on = (y == SPR_H / 2) || (x == SPR_W / 3 && y < SPR_H / 2);
          default:   on = (y == SPR_H / 2) || (x == SPR_W / 3 && y > SPR_H / 2);
        endcase
        bm[y * SPR_W + x] = on;
      end
    end
    return bm;
  endfunction

  localparam logic [NPIX-1:0] BM_CAC3   = draw(SH_CAC3);
  localparam logic [NPIX-1:0] BM_CAC2   = draw(SH_CAC2);
  localparam logic [NPIX-1:0] BM_THICK  = draw(SH_THICK);
  localparam logic [NPIX-1:0] BM_THIN   = draw(SH_THIN);
  localparam logic [NPIX-1:0] BM_BIRD_A = draw(SH_BIRD_A);
  localparam logic [NPIX-1:0] BM_BIRD_B = draw(SH_BIRD_B);

  logic          released;
  logic [CW-1:0] anim_cnt;
  logic          in_range;
  logic          flip;
  logic [XW-1:0] x_eff;
  logic [IW-1:0] idx;
  logic          pix;

`ifdef OBS_ROM_HFLIP_EN
  assign flip = i_hflip;
`else
  assign flip = 1'b0;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    in_range = ({1'b0, i_x} < (XW + 1)'(SPR_W)) && ({1'b0, i_y} < (YW + 1)'(SPR_H));
    x_eff    = flip ? (XW'(SPR_W - 1) - i_x) : i_x;
    idx      = '0;
    pix      = 1'b0;
    if (in_range) idx = IW'(i_y) * IW'(SPR_W) + IW'(x_eff);
    case (obs_type_e'(i_obs_type))
      T_CAC_3:                      pix = BM_CAC3[idx];
      T_CAC_2:                      pix = BM_CAC2[idx];
      T_CAC_THICK_1, T_CAC_THICK_2: pix = BM_THICK[idx];
      T_CAC_THIN:                   pix = BM_THIN[idx];
      T_BIRD_LOW, T_BIRD_HIGH:      pix = o_anim_frame ? BM_BIRD_B[idx] : BM_BIRD_A[idx];
      default:                      pix = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // The bitmaps are constants, not storage, so only the output and animation flops need reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      released       <= 1'b0;
      o_pix_valid    <= 1'b0;
      o_sprite_color <= 1'b0;
      o_oob          <= 1'b0;
    end else begin
      // The first edge after release only arms the block; requests there are dropped.
      released       <= 1'b1;
      o_pix_valid    <= i_req_valid & released;
      o_sprite_color <= i_req_valid & released & in_range & pix;
      o_oob          <= i_req_valid & released & ~in_range;
    end
  end

  // Frame register is read by the pixel path above, so a coincident tick only affects later requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anim_cnt     <= '0;
      o_anim_frame <= 1'b0;
    end else if (i_frame_tick && i_anim_run) begin
      if (anim_cnt == CW'(ANIM_DIV - 1)) begin
        anim_cnt     <= '0;
        o_anim_frame <= ~o_anim_frame;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obs_sprite_rom.sv
// Bench for obs_sprite_rom: a 16x16 (ANIM_DIV=8) and a 12x10 (ANIM_DIV=4) instance share one stimulus
// stream and are checked against a shape-rule model. Define OBS_ROM_HFLIP_EN to also exercise mirroring.
module tb_obs_sprite_rom;

  typedef struct packed {logic v; logic c; logic o; logic f;} obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [3:0] x, y;
  logic [2:0] typ;
  logic       tick, run, hflip;
  logic       a_valid, a_color, a_oob, a_frame;
  logic       b_valid, b_color, b_oob, b_frame;

  int   n_chk = 0;
  int   n_fail = 0;
  int   a_cnt, b_cnt;
  logic a_fr, b_fr;
  bit   released;
  obs_t exp_a, exp_b;

  always #5 clk = ~clk;

  obs_sprite_rom u_big (
    .clk(clk), .rst(rst), .i_req_valid(req), .i_x(x), .i_y(y), .i_obs_type(typ),
    .i_frame_tick(tick), .i_anim_run(run),
`ifdef OBS_ROM_HFLIP_EN
    .i_hflip(hflip),
`endif
    .o_pix_valid(a_valid), .o_sprite_color(a_color), .o_oob(a_oob), .o_anim_frame(a_frame)
  );

  obs_sprite_rom #(.SPR_W(12), .SPR_H(10), .ANIM_DIV(4)) u_odd (
    .clk(clk), .rst(rst), .i_req_valid(req), .i_x(x), .i_y(y), .i_obs_type(typ),
    .i_frame_tick(tick), .i_anim_run(run),
`ifdef OBS_ROM_HFLIP_EN
    .i_hflip(hflip),
`endif
    .o_pix_valid(b_valid), .o_sprite_color(b_color), .o_oob(b_oob), .o_anim_frame(b_frame)
  );

  // Reference pixel straight from the shape rules of each obstacle kind.
  function automatic logic golden(int w, int h, int t, int px, int py, logic fr, logic hf);
    int xx;
    if (px >= w || py >= h) return 1'b0;
    xx = hf ? (w - 1 - px) : px;
    case (t)
      1:       return (xx % 5 == 1) && (py >= h / 4);
      2:       return (xx % 6 == 2) || (py == h - 1);
      3, 4:    return (xx >= w / 4 && xx < (3 * w) / 4) || (py == h / 3 && xx >= (3 * w) / 4);
      5:       return (xx == w / 2) || (py == h / 2 && xx < w / 2);
      6, 7:    return (py == h / 2) || (xx == w / 3 && (fr ? (py > h / 2) : (py < h / 2)));
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t predict(int w, int h, logic fr_pre, logic fr_post);
    obs_t r;
    logic hf;
`ifdef OBS_ROM_HFLIP_EN
    hf = hflip;
`else
    hf = 1'b0;
`endif
    r.v = req && released;
    r.c = r.v && golden(w, h, int'(typ), int'(x), int'(y), fr_pre, hf);
    r.o = r.v && (int'(x) >= w || int'(y) >= h);
    r.f = fr_post;
    return r;
  endfunction

  // Advances the model by one clock with the inputs currently driven, then waits to the sampling edge.
  task automatic cycle();
    logic af0, bf0;
    af0 = a_fr;
    bf0 = b_fr;
    if (tick && run) begin
      a_cnt++;
      if (a_cnt == 8) begin a_cnt = 0; a_fr = ~a_fr; end
      b_cnt++;
      if (b_cnt == 4) begin b_cnt = 0; b_fr = ~b_fr; end
    end
    exp_a = predict(16, 16, af0, a_fr);
    exp_b = predict(12, 10, bf0, b_fr);
    released = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req = 0; x = 0; y = 0; typ = 0; tick = 0; run = 1; hflip = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    a_cnt = 0; b_cnt = 0; a_fr = 0; b_fr = 0; released = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({a_valid, a_color, a_oob, a_frame, b_valid, b_color, b_oob, b_frame} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state got=%b%b%b%b_%b%b%b%b want=0000_0000",
               a_valid, a_color, a_oob, a_frame, b_valid, b_color, b_oob, b_frame);
    end
    rst = 1'b0;
    a_cnt = 0; b_cnt = 0; a_fr = 0; b_fr = 0; released = 0;
    req = 1; typ = 5; x = 8; y = 3;
    repeat (3) begin
      cycle();
      n_chk++;
      if ({a_valid, a_color, a_oob, a_frame} !== exp_a) begin
        n_fail++;
        $display("FAIL reset_prestream got=%b want=%b", {a_valid, a_color, a_oob, a_frame}, exp_a);
      end
    end
    // Assert reset mid-cycle with a request still presented.
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({a_valid, a_color, a_oob, a_frame, b_valid, b_color, b_oob, b_frame} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async got=%b%b%b%b_%b%b%b%b want=0000_0000",
               a_valid, a_color, a_oob, a_frame, b_valid, b_color, b_oob, b_frame);
    end
    @(negedge clk);
    rst = 1'b0;
    a_cnt = 0; b_cnt = 0; a_fr = 0; b_fr = 0; released = 0;
    cycle();
    n_chk++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_edge got=%b%b want=00", a_valid, b_valid);
    end
    cycle();
    n_chk++;
    if (a_valid !== 1'b1 || b_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_second_edge got=%b%b want=11", a_valid, b_valid);
    end
  endtask

  task automatic test_sweep();
    for (int t = 1; t <= 7; t++) begin
      for (int py = 0; py < 16; py++) begin
        for (int px = 0; px < 16; px++) begin
          req = ($urandom_range(7) != 0); typ = 3'(t); x = 4'(px); y = 4'(py);
          tick = $urandom_range(1); run = 1;
          cycle();
          n_chk++;
          if ({a_valid, a_color, a_oob, a_frame} !== exp_a) begin
            n_fail++;
            $display("FAIL sweep_16x16 t=%0d x=%0d y=%0d got=%b want=%b",
                     t, px, py, {a_valid, a_color, a_oob, a_frame}, exp_a);
          end
          n_chk++;
          if ({b_valid, b_color, b_oob, b_frame} !== exp_b) begin
            n_fail++;
            $display("FAIL sweep_12x10 t=%0d x=%0d y=%0d got=%b want=%b",
                     t, px, py, {b_valid, b_color, b_oob, b_frame}, exp_b);
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_empty_oob();
    req = 1; typ = 0; x = 5; y = 5;
    cycle();
    n_chk++;
    if ({a_valid, a_color, a_oob} !== 3'b100) begin
      n_fail++;
      $display("FAIL empty_5_5 got=%b want=100", {a_valid, a_color, a_oob});
    end
    typ = 5; x = 13; y = 2;
    cycle();
    n_chk++;
    if ({b_valid, b_color, b_oob} !== 3'b101) begin
      n_fail++;
      $display("FAIL oob_x13 got=%b want=101", {b_valid, b_color, b_oob});
    end
    n_chk++;
    if ({a_valid, a_color, a_oob, a_frame} !== exp_a) begin
      n_fail++;
      $display("FAIL inrange_x13_big got=%b want=%b", {a_valid, a_color, a_oob, a_frame}, exp_a);
    end
    idle_inputs();
  endtask

  task automatic test_anim();
    do_reset();
    tick = 1; run = 1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_chk++;
      if (b_frame !== (i == 4) || a_frame !== 1'b0) begin
        n_fail++;
        $display("FAIL anim_run tick=%0d got=%b%b want=0%b", i, a_frame, b_frame, i == 4);
      end
    end
    run = 0;
    repeat (3) begin
      cycle();
      n_chk++;
      if (b_frame !== 1'b1 || a_frame !== 1'b0) begin
        n_fail++;
        $display("FAIL anim_frozen got=%b%b want=01", a_frame, b_frame);
      end
    end
    run = 1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      n_chk++;
      if ({a_frame, b_frame} !== {a_fr, b_fr}) begin
        n_fail++;
        $display("FAIL anim_more tick=%0d got=%b%b want=%b%b", i, a_frame, b_frame, a_fr, b_fr);
      end
    end
    n_chk++;
    if (b_frame !== 1'b1 || a_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL anim_final got=%b%b want=11", a_frame, b_frame);
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    do_reset();
    tick = 1; run = 1;
    repeat (3) cycle();
    // Fourth tick coincides with a bird request at a pixel that differs between the two frames.
    req = 1; typ = 6; x = 4; y = 4;
    cycle();
    n_chk++;
    if (b_color !== 1'b1 || b_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_pre got=c%b f%b want=c1 f1", b_color, b_frame);
    end
    tick = 0;
    cycle();
    n_chk++;
    if (b_color !== 1'b0 || {a_valid, a_color, a_oob, a_frame} !== exp_a) begin
      n_fail++;
      $display("FAIL collision_post got=c%b big=%b want=c0 big=%b",
               b_color, {a_valid, a_color, a_oob, a_frame}, exp_a);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 600; i++) begin
      req = ($urandom_range(3) != 0); typ = 3'($urandom_range(7));
      x = 4'($urandom_range(15)); y = 4'($urandom_range(15));
      tick = ($urandom_range(2) == 0); run = ($urandom_range(3) != 0); hflip = 1'($urandom_range(1));
      cycle();
      n_chk++;
      if ({a_valid, a_color, a_oob, a_frame} !== exp_a ||
          {b_valid, b_color, b_oob, b_frame} !== exp_b) begin
        n_fail++;
        $display("FAIL random i=%0d t=%0d x=%0d y=%0d got=%b_%b want=%b_%b", i, typ, x, y,
                 {a_valid, a_color, a_oob, a_frame}, {b_valid, b_color, b_oob, b_frame}, exp_a, exp_b);
      end
    end
    idle_inputs();
  endtask

`ifdef OBS_ROM_HFLIP_EN
  task automatic test_hflip();
    req = 1; typ = 5; x = 0; y = 8; hflip = 1;
    cycle();
    n_chk++;
    if (a_color !== 1'b0 || a_color !== exp_a.c) begin
      n_fail++;
      $display("FAIL hflip_thin got=%b want=0", a_color);
    end
    hflip = 0;
    cycle();
    n_chk++;
    if (a_color !== 1'b1) begin
      n_fail++;
      $display("FAIL hflip_off_thin got=%b want=1", a_color);
    end
    x = 13; y = 2; hflip = 1;
    cycle();
    n_chk++;
    if ({b_valid, b_color, b_oob} !== 3'b101) begin
      n_fail++;
      $display("FAIL hflip_oob got=%b want=101", {b_valid, b_color, b_oob});
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_empty_oob();
    test_anim();
    test_collision();
`ifdef OBS_ROM_HFLIP_EN
    test_hflip();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
